fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares the 128-bit FIFO write port between NUM_REQ producers. It sits directly in front of the FIFO. It drives i_wren/i_wrdata from a registered output stage and throttles on o_full/o_alm_full so that no write is ever issued into a full FIFO. Each grant can be held for a bounded burst, so a producer keeps ownership for consecutive beats.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 128, write data width; matches the FIFO data width
- MAX_BURST, 4, maximum consecutive transfers per grant (1..255)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  write-side clock shared with the FIFO
- rstn  in  1  asynchronous active-low reset
- cfg_en  in  NUM_REQ  per-requester enable mask; a disabled requester is never granted
- req_valid  in  NUM_REQ  requester i has a beat pending
- req_data  in  NUM_REQ*DATA_W  beat for requester i, at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot or zero; beat i transfers on a clock edge with req_valid[i] & req_ready[i]
- fifo_full  in  1  FIFO o_full
- fifo_alm_full  in  1  FIFO o_alm_full; asserted when ≤1 free slot
- fifo_wren  out  1  to FIFO i_wren; registered
- fifo_wrdata  out  DATA_W  to FIFO i_wrdata; registered
- grant_id  out  $clog2(NUM_REQ)  index of the current or last holder; registered
- busy  out  1  state == BURST

## Operation
- issue_ok = !fifo_full && !(fifo_alm_full && fifo_wren).
  - A registered write in flight consumes the last slot, so the arbiter holds while it lands.
- eligible[i] = req_valid[i] & cfg_en[i].
- States:
  - IDLE: if issue_ok and any eligible, grant the first eligible index searching from rr_ptr upward with wrap. Assert its req_ready; the transfer happens this cycle. Load holder := i and burst_cnt := 1. Go to BURST unless MAX_BURST == 1, in which case stay in IDLE with rr_ptr := i+1.
  - BURST: req_ready[holder] = issue_ok && eligible[holder]. Each transfer increments burst_cnt. Return to IDLE with rr_ptr := holder+1 (mod NUM_REQ) when either:
    - a transfer makes burst_cnt == MAX_BURST, or
    - eligible[holder] is low on a clock edge. This costs one bubble cycle; no other requester is granted in that cycle.
- A stall (issue_ok low) neither ends a burst nor counts toward it.
- Transfer at edge t gives fifo_wren = 1 and fifo_wrdata = beat during cycle t+1. With no transfer, fifo_wren = 0 and fifo_wrdata holds its last value.
- req_ready is combinational from state, eligible, fifo_full, fifo_alm_full and fifo_wren. It never depends on req_data.
- Producers must hold req_valid and req_data stable until the transfer.

## Timing
- Reset values:
  - outputs: fifo_wren 0, fifo_wrdata 0, grant_id 0, busy 0, req_ready 0
  - internal: state IDLE, rr_ptr 0, burst_cnt 0
- Reset assertion mid-burst clears everything immediately. A pending registered write is dropped (fifo_wren forced 0).
- Latency: 1 cycle from accepted beat to FIFO write. Throughput is 1 beat/cycle while issue_ok holds.
- Full boundary: with fifo_alm_full = 1 and fifo_wren = 0, exactly one more beat is accepted. The next cycle it is blocked until alm_full drops.
- rr_ptr wraps from NUM_REQ-1 to 0. burst_cnt width is 8 bits.

## Structure
- Package fifo_arb_pkg holds:
  - arb_state_e {IDLE, BURST}
  - the helper function for the rotate-from-pointer first-one search
- One sub-module is natural: rr_pick, the combinational round-robin picker.
  - Inputs: eligible vector, rr_ptr. Outputs: grant index, any.
  - It is reused by the planned read-side scheduler.

## Test plan
- Single requester 2 valid 6 beats, MAX_BURST = 4, FIFO empty:
  - beats accepted on consecutive edges
  - fifo_wren high 6 cycles, each beat one cycle after its accept
  - burst_cnt reaches 4; IDLE costs no bubble since requester 2 regains the grant at once; grant_id = 2
- All 4 requesters always valid, MAX_BURST = 2:
  - grant order 0,0,1,1,2,2,3,3,0,0
  - no overlap in req_ready
- fifo_alm_full = 1 with an idle pipe:
  - one beat accepted
  - next cycle req_ready = 0
  - fifo_full = 1 afterwards → no further fifo_wren pulse
- cfg_en = 4'b1010, all requesters valid:
  - only 1 and 3 are granted, alternating per burst
  - dropping cfg_en[1] mid-burst returns to IDLE at the next edge
- rstn low mid-burst with fifo_wren = 1:
  - fifo_wren 0 immediately (async)
  - after release, first grant goes to requester 0
- Holder drops valid after 1 of 4 beats:
  - one bubble cycle
  - then requester holder+1 is granted

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotate-from-pointer first-one search used by the
// write arbiter and the round-robin picker.
package fifo_arb_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned IDX_MAX_W = 4;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // First set bit of elig[n-1:0], scanning upward from ptr with wrap at n.
  function automatic logic [IDX_MAX_W-1:0] rr_first(
    input logic [MAX_REQ-1:0]   elig,
    input logic [IDX_MAX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [IDX_MAX_W-1:0] sel;
    logic                 found;
    int unsigned          idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && elig[IDX_MAX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_MAX_W'(idx);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr,
// wrapping; shared between the write arbiter and the read-side scheduler.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0]   elig_ext;
  logic [IDX_MAX_W-1:0] ptr_ext;

  assign elig_ext = MAX_REQ'(eligible);
  assign ptr_ext  = IDX_MAX_W'(rr_ptr);
  assign grant    = IDX_W'(rr_first(elig_ext, ptr_ext, NUM_REQ));
  assign any      = |eligible;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port; registered write
// stage with full/almost-full throttling so the FIFO is never overrun.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          cfg_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  input  logic                        fifo_alm_full,
  output logic                        fifo_wren,
  output logic [DATA_W-1:0]           fifo_wrdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   holder_q, holder_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               wren_q, wren_d;
  logic [DATA_W-1:0]  wrdata_q, wrdata_d;

  logic [NUM_REQ-1:0] eligible;
  logic               issue_ok;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] ready_c;
  logic               xfer_c;
  logic [DATA_W-1:0]  beat_c;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : IDX_W'(32'(i) + 1);
  endfunction

  // An in-flight write plus almost-full means the last slot is already spoken for.
  assign issue_ok = !fifo_full && !(fifo_alm_full && wren_q);
  assign eligible = req_valid & cfg_en;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .grant    (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      holder_q    <= '0;
      burst_cnt_q <= '0;
      wren_q      <= 1'b0;
      wrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      holder_q    <= holder_d;
      burst_cnt_q <= burst_cnt_d;
      wren_q      <= wren_d;
      wrdata_q    <= wrdata_d;
    end
  end

  // Grant selection, handshake and write-stage data.
  always_comb begin
    ready_c = '0;
    beat_c  = '0;
    sel_idx = (state_q == IDLE) ? pick_idx : holder_q;
    if (state_q == IDLE) begin
      if (issue_ok && pick_any) ready_c[pick_idx] = 1'b1;
    end else if (issue_ok && eligible[holder_q]) begin
      ready_c[holder_q] = 1'b1;
    end
    xfer_c = |ready_c;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_idx == IDX_W'(i)) beat_c = req_data[i*DATA_W +: DATA_W];
    end
    wren_d   = xfer_c;
    wrdata_d = xfer_c ? beat_c : wrdata_q;
  end

  // Burst sequencing; a stall leaves everything untouched.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    holder_d    = holder_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          holder_d    = pick_idx;
          burst_cnt_d = CNT_W'(1);
          if (MAX_BURST == 1) rr_ptr_d = next_idx(pick_idx);
          else                state_d  = BURST;
        end
      end
      BURST: begin
        if (!eligible[holder_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(holder_q);
        end else if (xfer_c) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_d == CNT_W'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(holder_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = ready_c;
  assign fifo_wren   = wren_q;
  assign fifo_wrdata = wrdata_q;
  assign grant_id    = holder_q;
  assign busy        = (state_q == BURST);

endmodule
